// File: rtl/pcie_fifo_arbiter_pkg.sv
// Shared types and defaults for the PCIe FIFO round-robin arbiter.
package pcie_fifo_arbiter_pkg;

   localparam int NUM_REQ_DEF    = 4;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int MAX_BURST_DEF  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Index base+off taken modulo n, used for the rotating priority scan.
   function automatic int unsigned wrap_idx(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/pcie_fifo_arbiter_if.sv
// Handshake bundle between source FIFOs, the arbiter and the lane stage.
interface pcie_fifo_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
) ();
   localparam int GW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            fifo_empty;
   logic [NUM_REQ*DATA_WIDTH-1:0] fifo_data;
   logic                          dest_almost_full;
   logic [NUM_REQ-1:0]            fifo_pop;
   logic [DATA_WIDTH-1:0]         data_out;
   logic                          valid_out;
   logic [GW-1:0]                 grant;
   logic                          idle;

   modport master (
      input  fifo_empty, fifo_data, dest_almost_full,
      output fifo_pop, data_out, valid_out, grant, idle
   );

   modport slave (
      output fifo_empty, fifo_data, dest_almost_full,
      input  fifo_pop, data_out, valid_out, grant, idle
   );
endinterface

// File: rtl/pcie_fifo_arbiter_rr_select.sv
// Rotating priority encoder: first non-empty FIFO after last_grant, wrapping.
module pcie_rr_select
   import pcie_fifo_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   localparam int GW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] fifo_empty_i,
   input  logic [GW-1:0]      last_grant_i,
   output logic               found_o,
   output logic [GW-1:0]      pick_o
);

   logic          found_s;
   logic [GW-1:0] pick_s;
   logic [GW-1:0] idx_s;

   // Scan offsets 1..NUM_REQ so the previous owner has lowest priority.
   always_comb begin
      found_s = 1'b0;
      pick_s  = '0;
      idx_s   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_s = GW'(wrap_idx(32'(last_grant_i), k, NUM_REQ));
         if (!found_s && !fifo_empty_i[idx_s]) begin
            found_s = 1'b1;
            pick_s  = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign found_o = found_s;
   assign pick_o  = pick_s;

endmodule

// File: rtl/pcie_fifo_arbiter.sv
// Round-robin burst arbiter popping per-channel FIFOs onto one registered byte lane.
module pcie_fifo_arbiter
   import pcie_fifo_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int MAX_BURST  = MAX_BURST_DEF
) (
   input logic                 clk_i,
   input logic                 rst_i,
   pcie_fifo_arbiter_if.master bus
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [GW-1:0] LAST_RST   = GW'(NUM_REQ - 1);

   state_e                state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [GW-1:0]         last_grant_q, last_grant_d;
   logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;

   logic                  found_s;
   logic [GW-1:0]         pick_s;
   logic                  send_ok_s;
   logic [NUM_REQ-1:0]    pop_s;

   pcie_rr_select #(.NUM_REQ(NUM_REQ)) u_sel (
      .fifo_empty_i (bus.fifo_empty),
      .last_grant_i (last_grant_q),
      .found_o      (found_s),
      .pick_o       (pick_s)
   );

   // Pop strobe is gated by reset so nothing leaves a FIFO on a reset edge.
   always_comb begin
      pop_s     = '0;
      send_ok_s = (state_q == ST_SEND) && !bus.fifo_empty[grant_q]
                  && !bus.dest_almost_full && !rst_i;
      if (send_ok_s) begin
         pop_s[grant_q] = 1'b1;
      end else begin
         pop_s = '0;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      burst_cnt_d  = burst_cnt_q;
      valid_d      = send_ok_s;
      data_d       = data_q;
      if (send_ok_s) begin
         data_d = bus.fifo_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         data_d = data_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (!bus.dest_almost_full && found_s) begin
               state_d      = ST_SEND;
               grant_d      = pick_s;
               last_grant_d = pick_s;
               burst_cnt_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (send_ok_s) begin
               burst_cnt_d = burst_cnt_q + BW'(1);
               if (burst_cnt_q == BURST_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_SEND;
               end
            end else if (bus.fifo_empty[grant_q]) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SEND;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_RST;
         burst_cnt_q  <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         burst_cnt_q  <= burst_cnt_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
      end
   end

   assign bus.fifo_pop  = pop_s;
   assign bus.data_out  = data_q;
   assign bus.valid_out = valid_q;
   assign bus.grant     = grant_q;
   assign bus.idle      = (state_q == ST_IDLE) && (&bus.fifo_empty);

endmodule

// File: tb/tb_pcie_fifo_arbiter.sv
// Directed bench for pcie_fifo_arbiter with a small pointer-based FIFO model.
module tb_pcie_fifo_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   logic [7:0] mem [4][16];
   int         rp [4];
   int         wp [4];
   logic [3:0] last_pop;

   always #5 clk = ~clk;

   pcie_fifo_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

   pcie_fifo_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         bus.fifo_empty[i]       = (rp[i] == wp[i]);
         bus.fifo_data[i*8 +: 8] = (rp[i] == wp[i]) ? 8'h00 : mem[i][rp[i]];
      end
   endtask

   task automatic clear();
      for (int i = 0; i < 4; i++) begin
         rp[i] = 0;
         wp[i] = 0;
      end
   endtask

   task automatic push(input int f, input logic [7:0] v);
      mem[f][wp[f]] = v;
      wp[f]++;
   endtask

   // One clock: sample pop before the edge, retire popped bytes after it.
   task automatic step();
      #1;
      last_pop = bus.fifo_pop;
      chk("onehot", 32'($countones(last_pop) <= 1), 32'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (last_pop[i]) rp[i]++;
      end
      drive();
      @(negedge clk);
   endtask

   task automatic pop_byte(input string tag, input logic [3:0] exp_pop, input logic [7:0] exp_d);
      step();
      chk({tag, "_pop"}, 32'(last_pop), 32'(exp_pop));
      chk({tag, "_vld"}, 32'(bus.valid_out), 32'd1);
      chk({tag, "_dat"}, 32'(bus.data_out), 32'(exp_d));
   endtask

   task automatic bubble(input string tag, input logic [1:0] exp_g);
      step();
      chk({tag, "_bpop"}, 32'(last_pop), 32'd0);
      chk({tag, "_gnt"}, 32'(bus.grant), 32'(exp_g));
   endtask

   initial begin
      bus.dest_almost_full = 1'b0;
      clear();
      drive();
      @(negedge clk);

      // 1: reset with every FIFO holding data
      rst = 1'b1;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 8; j++) push(i, 8'(8'h10 * i + j));
      drive();
      for (int c = 0; c < 2; c++) begin
         step();
         chk("t1_pop", 32'(last_pop), 32'd0);
      end
      chk("t1_vld", 32'(bus.valid_out), 32'd0);
      chk("t1_dat", 32'(bus.data_out), 32'h00);
      chk("t1_gnt", 32'(bus.grant), 32'd0);
      chk("t1_idle", 32'(bus.idle), 32'd0);

      // 2: lone requester FIFO1
      clear();
      push(1, 8'hA1);
      push(1, 8'hA2);
      drive();
      rst = 1'b0;
      bubble("t2", 2'd1);
      pop_byte("t2a", 4'b0010, 8'hA1);
      pop_byte("t2b", 4'b0010, 8'hA2);
      step();
      chk("t2_endpop", 32'(last_pop), 32'd0);
      chk("t2_endvld", 32'(bus.valid_out), 32'd0);
      chk("t2_hold", 32'(bus.data_out), 32'hA2);
      chk("t2_idle", 32'(bus.idle), 32'd1);

      // 3: all four FIFOs full, fresh rotation from 0
      clear();
      for (int i = 0; i < 4; i++) for (int j = 0; j < 8; j++) push(i, 8'(8'h10 * i + j));
      rst = 1'b1;
      drive();
      step();
      rst = 1'b0;
      for (int b = 0; b < 8; b++) begin
         bubble("t3", 2'(b % 4));
         for (int m = 0; m < 4; m++) begin
            pop_byte("t3", 4'(4'b0001 << (b % 4)), 8'(8'h10 * (b % 4) + (b / 4) * 4 + m));
         end
      end
      step();
      chk("t3_endvld", 32'(bus.valid_out), 32'd0);
      chk("t3_idle", 32'(bus.idle), 32'd1);

      // 4: backpressure mid-burst on FIFO2
      clear();
      for (int j = 0; j < 5; j++) push(2, 8'(8'hC0 + j));
      drive();
      bubble("t4", 2'd2);
      pop_byte("t4a", 4'b0100, 8'hC0);
      pop_byte("t4b", 4'b0100, 8'hC1);
      bus.dest_almost_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t4_afpop", 32'(last_pop), 32'd0);
         chk("t4_afvld", 32'(bus.valid_out), 32'd0);
         chk("t4_afdat", 32'(bus.data_out), 32'hC1);
      end
      bus.dest_almost_full = 1'b0;
      pop_byte("t4c", 4'b0100, 8'hC2);
      pop_byte("t4d", 4'b0100, 8'hC3);
      bubble("t4re", 2'd2);
      pop_byte("t4e", 4'b0100, 8'hC4);
      step();
      chk("t4_endpop", 32'(last_pop), 32'd0);
      chk("t4_idle", 32'(bus.idle), 32'd1);

      // 5: FIFO3 runs dry after two bytes, FIFO0 waiting
      clear();
      push(3, 8'hD0);
      push(3, 8'hD1);
      push(0, 8'hE0);
      push(0, 8'hE1);
      drive();
      bubble("t5", 2'd3);
      pop_byte("t5a", 4'b1000, 8'hD0);
      pop_byte("t5b", 4'b1000, 8'hD1);
      step();
      chk("t5_drypop", 32'(last_pop), 32'd0);
      chk("t5_dryvld", 32'(bus.valid_out), 32'd0);
      bubble("t5n", 2'd0);
      pop_byte("t5c", 4'b0001, 8'hE0);
      pop_byte("t5d", 4'b0001, 8'hE1);
      step();
      chk("t5_idle", 32'(bus.idle), 32'd1);

      // 6: reset on the third pop cycle of a FIFO1 burst
      clear();
      for (int j = 0; j < 4; j++) push(1, 8'(8'hF0 + j));
      push(0, 8'h5A);
      drive();
      bubble("t6", 2'd1);
      pop_byte("t6a", 4'b0010, 8'hF0);
      pop_byte("t6b", 4'b0010, 8'hF1);
      rst = 1'b1;
      step();
      chk("t6_rstpop", 32'(last_pop), 32'd0);
      chk("t6_rstvld", 32'(bus.valid_out), 32'd0);
      chk("t6_rstdat", 32'(bus.data_out), 32'h00);
      chk("t6_rstgnt", 32'(bus.grant), 32'd0);
      rst = 1'b0;
      bubble("t6n", 2'd0);
      pop_byte("t6c", 4'b0001, 8'h5A);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
